// File: rtl/riscv_dmem_arb.sv
// -----------------------------------------------------------------------------
// riscv_dmem_arb
//
// Shares the single data-memory port between the EX-stage load/store path
// (ex_*) and the debug unit (du_*). One transaction is outstanding at a time.
// The winner's request is latched into mem_* and held until the memory answers
// with mem_ack/mem_err or the watchdog expires. The response is steered back to
// the granted requester only.
//
// Parameters
//   XLEN       data/address width
//   DU_PRIO    0: round-robin between EX and DU, 1: DU has fixed priority
//   TIMEOUT    BUSY cycles before the watchdog aborts (0 disables it)
//   TMO_W      watchdog counter width (TIMEOUT < 2**TMO_W)
//   biu_size_t access-size type shared with the bus interface
//
// Ports
//   clk, rst                        clock, synchronous active-high reset
//   ex_req/adr/d/we/size            EX request (req held until ack or err)
//   ex_ack/err/q                    EX response (ack/err are 1-cycle pulses)
//   du_req/adr/d/we/size            debug-unit request
//   du_ack/err/q                    debug-unit response
//   mem_req/adr/d/we/size           registered request to memory / DCACHE
//   mem_ack/q/err                   memory response
//   arb_busy                        transaction outstanding
//   arb_gnt_du                      current/last grant went to the debug unit
// -----------------------------------------------------------------------------
module riscv_dmem_arb #(
  parameter int  XLEN       = 32,
  parameter int  DU_PRIO    = 0,
  parameter int  TIMEOUT    = 0,
  parameter int  TMO_W      = 16,
  parameter type biu_size_t = logic [2:0]
) (
  input  logic            clk,
  input  logic            rst,
  // EX-stage load/store path
  input  logic            ex_req,
  input  logic [XLEN-1:0] ex_adr,
  input  logic [XLEN-1:0] ex_d,
  input  logic            ex_we,
  input  biu_size_t       ex_size,
  output logic            ex_ack,
  output logic            ex_err,
  output logic [XLEN-1:0] ex_q,
  // debug-unit memory path
  input  logic            du_req,
  input  logic [XLEN-1:0] du_adr,
  input  logic [XLEN-1:0] du_d,
  input  logic            du_we,
  input  biu_size_t       du_size,
  output logic            du_ack,
  output logic            du_err,
  output logic [XLEN-1:0] du_q,
  // memory / DCACHE side
  output logic            mem_req,
  output logic [XLEN-1:0] mem_adr,
  output logic [XLEN-1:0] mem_d,
  output logic            mem_we,
  output biu_size_t       mem_size,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_q,
  input  logic            mem_err,
  // status
  output logic            arb_busy,
  output logic            arb_gnt_du
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  localparam bit TMO_EN = (TIMEOUT != 0);
  // The counter starts at 0 in the first BUSY cycle, so the N-th BUSY cycle
  // holds count N-1; the abort fires in the TIMEOUT-th cycle.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_EN ? TMO_W'(TIMEOUT - 1) : '0;

  logic [0:0]       state_reg;
  logic             last_du_reg;   // last grant pointer for round-robin
  logic             gnt_du_reg;    // owner of the current/last transaction
  logic [TMO_W-1:0] tmo_cnt_reg;

  logic busy;
  logic tmo_hit;
  logic done;
  logic resp_ack;
  logic resp_err;
  logic pick_du;

  always_comb begin
    busy    = (state_reg == BUSY);
    // A real response in the same cycle beats the watchdog.
    tmo_hit = TMO_EN && busy && !mem_ack && !mem_err && (tmo_cnt_reg == TMO_LAST);
    done    = busy && (mem_ack || mem_err || tmo_hit);
    // Responses are dropped while reset is asserted so an aborted transaction
    // never reports completion.
    resp_err = busy && !rst && (mem_err || tmo_hit);
    resp_ack = busy && !rst && mem_ack && !mem_err;
    // DU wins if it is alone, if it has fixed priority, or if EX went last.
    pick_du = du_req && ((DU_PRIO != 0) || !ex_req || !last_du_reg);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      last_du_reg <= 1'b1;
      gnt_du_reg  <= 1'b0;
      tmo_cnt_reg <= '0;
      mem_req     <= 1'b0;
      mem_adr     <= '0;
      mem_d       <= '0;
      mem_we      <= 1'b0;
      mem_size    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (ex_req || du_req) begin
            state_reg   <= BUSY;
            mem_req     <= 1'b1;
            mem_adr     <= pick_du ? du_adr  : ex_adr;
            mem_d       <= pick_du ? du_d    : ex_d;
            mem_we      <= pick_du ? du_we   : ex_we;
            mem_size    <= pick_du ? du_size : ex_size;
            gnt_du_reg  <= pick_du;
            last_du_reg <= pick_du;
            tmo_cnt_reg <= '0;
          end
        end
        BUSY: begin
          if (done) begin
            state_reg <= IDLE;
            mem_req   <= 1'b0;
          end else if (TMO_EN) begin
            tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);
          end
        end
        default: begin
          state_reg <= IDLE;
          mem_req   <= 1'b0;
        end
      endcase
    end
  end

  assign ex_ack     = resp_ack & ~gnt_du_reg;
  assign ex_err     = resp_err & ~gnt_du_reg;
  assign du_ack     = resp_ack &  gnt_du_reg;
  assign du_err     = resp_err &  gnt_du_reg;
  assign ex_q       = mem_q;
  assign du_q       = mem_q;
  assign arb_busy   = busy;
  assign arb_gnt_du = gnt_du_reg;

endmodule

// File: tb/tb_riscv_dmem_arb.sv
// -----------------------------------------------------------------------------
// tb_riscv_dmem_arb
//
// Two arbiters share one stimulus set: "dut" is round-robin with a 4-cycle
// watchdog, "dut_p" gives the debug unit fixed priority with no watchdog.
// Each instance has its own req lines; address/data and memory responses are
// shared (an idle arbiter ignores memory responses).
// Expected grants are predicted by a small arbitration model when requests are
// driven, queued, and popped when mem_req rises.
// -----------------------------------------------------------------------------
module tb_riscv_dmem_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        ex_req, du_req, p_ex_req, p_du_req;
  logic [31:0] ex_adr, ex_d, du_adr, du_d, mem_q;
  logic        ex_we, du_we, mem_ack, mem_err;
  logic [2:0]  ex_size, du_size;

  logic        ex_ack, ex_err, du_ack, du_err, mem_req, mem_we, arb_busy, arb_gnt_du;
  logic [31:0] ex_q, du_q, mem_adr, mem_d;
  logic [2:0]  mem_size;

  logic        p_ex_ack, p_ex_err, p_du_ack, p_du_err, p_mem_req, p_mem_we, p_arb_busy, p_arb_gnt_du;
  logic [31:0] p_ex_q, p_du_q, p_mem_adr, p_mem_d;
  logic [2:0]  p_mem_size;

  riscv_dmem_arb #(.XLEN(32), .DU_PRIO(0), .TIMEOUT(4), .TMO_W(16)) dut (
    .clk(clk), .rst(rst),
    .ex_req(ex_req), .ex_adr(ex_adr), .ex_d(ex_d), .ex_we(ex_we), .ex_size(ex_size),
    .ex_ack(ex_ack), .ex_err(ex_err), .ex_q(ex_q),
    .du_req(du_req), .du_adr(du_adr), .du_d(du_d), .du_we(du_we), .du_size(du_size),
    .du_ack(du_ack), .du_err(du_err), .du_q(du_q),
    .mem_req(mem_req), .mem_adr(mem_adr), .mem_d(mem_d), .mem_we(mem_we), .mem_size(mem_size),
    .mem_ack(mem_ack), .mem_q(mem_q), .mem_err(mem_err),
    .arb_busy(arb_busy), .arb_gnt_du(arb_gnt_du)
  );

  riscv_dmem_arb #(.XLEN(32), .DU_PRIO(1), .TIMEOUT(0), .TMO_W(16)) dut_p (
    .clk(clk), .rst(rst),
    .ex_req(p_ex_req), .ex_adr(ex_adr), .ex_d(ex_d), .ex_we(ex_we), .ex_size(ex_size),
    .ex_ack(p_ex_ack), .ex_err(p_ex_err), .ex_q(p_ex_q),
    .du_req(p_du_req), .du_adr(du_adr), .du_d(du_d), .du_we(du_we), .du_size(du_size),
    .du_ack(p_du_ack), .du_err(p_du_err), .du_q(p_du_q),
    .mem_req(p_mem_req), .mem_adr(p_mem_adr), .mem_d(p_mem_d), .mem_we(p_mem_we), .mem_size(p_mem_size),
    .mem_ack(mem_ack), .mem_q(mem_q), .mem_err(mem_err),
    .arb_busy(p_arb_busy), .arb_gnt_du(p_arb_gnt_du)
  );

  typedef struct {
    logic        du;
    logic [31:0] adr;
    logic [31:0] d;
    logic        we;
    logic [2:0]  size;
  } gnt_t;

  gnt_t       sb_q[$];
  gnt_t       cur_g;
  logic [1:0] model_last;   // per instance: 1 = last grant was DU
  int         n_tests = 0;
  int         n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input bit sel, input bit du, input logic v);
    if (sel) begin
      if (du) p_du_req = v; else p_ex_req = v;
    end else begin
      if (du) du_req = v; else ex_req = v;
    end
  endtask

  // Predict the next grant from the requesters present and push it.
  task automatic expect_grant(input bit sel, input bit ex, input bit du);
    gnt_t g;
    bit   w;
    w = du && (sel || !ex || !model_last[sel]);
    model_last[sel] = w;
    g.du   = w;
    g.adr  = w ? du_adr  : ex_adr;
    g.d    = w ? du_d    : ex_d;
    g.we   = w ? du_we   : ex_we;
    g.size = w ? du_size : ex_size;
    sb_q.push_back(g);
  endtask

  // Called in the cycle the requests are visible; returns at the first BUSY cycle.
  task automatic wait_grant(input bit sel, input string tag);
    int n;
    n = 0;
    @(negedge clk); #1;
    while (!(sel ? p_mem_req : mem_req) && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    chk({tag, ".req"}, 64'(sel ? p_mem_req : mem_req), 64'(1));
    chk({tag, ".lat"}, 64'(n), 64'(0));
    chk({tag, ".sb"}, 64'(sb_q.size() != 0), 64'(1));
    if (sb_q.size() != 0) cur_g = sb_q.pop_front();
    else cur_g = '{du: 1'b0, adr: 32'h0, d: 32'h0, we: 1'b0, size: 3'h0};
    chk({tag, ".adr"},  64'(sel ? p_mem_adr    : mem_adr),    64'(cur_g.adr));
    chk({tag, ".d"},    64'(sel ? p_mem_d      : mem_d),      64'(cur_g.d));
    chk({tag, ".we"},   64'(sel ? p_mem_we     : mem_we),     64'(cur_g.we));
    chk({tag, ".size"}, 64'(sel ? p_mem_size   : mem_size),   64'(cur_g.size));
    chk({tag, ".gnt"},  64'(sel ? p_arb_gnt_du : arb_gnt_du), 64'(cur_g.du));
    chk({tag, ".busy"}, 64'(sel ? p_arb_busy   : arb_busy),   64'(1));
    $display("[TB] %s grant du=%0d adr=%08h", tag, cur_g.du, cur_g.adr);
  endtask

  // Wait lat BUSY cycles (scrambling requester inputs), then respond and
  // check steering; finally check the arbiter is back in IDLE.
  task automatic serve(input bit sel, input int lat, input logic ack, input logic err,
                       input logic [31:0] q, input logic [1:0] drop, input string tag);
    logic [3:0]  resp;
    logic [3:0]  exp_resp;
    logic [31:0] qo;
    logic        ea;
    for (int i = 0; i < lat; i++) begin
      ex_adr = $urandom; du_adr = $urandom; ex_d = $urandom;
      resp = sel ? {p_du_err, p_du_ack, p_ex_err, p_ex_ack} : {du_err, du_ack, ex_err, ex_ack};
      chk({tag, ".wait"}, 64'(resp), 64'(0));
      @(negedge clk); #1;
      chk({tag, ".hold"}, 64'(sel ? p_mem_adr : mem_adr), 64'(cur_g.adr));
    end
    mem_q = q; mem_ack = ack; mem_err = err;
    #1;
    resp     = sel ? {p_du_err, p_du_ack, p_ex_err, p_ex_ack} : {du_err, du_ack, ex_err, ex_ack};
    ea       = ack & ~err;
    exp_resp = cur_g.du ? {err, ea, 2'b00} : {2'b00, err, ea};
    chk({tag, ".resp"}, 64'(resp), 64'(exp_resp));
    qo = cur_g.du ? (sel ? p_du_q : du_q) : (sel ? p_ex_q : ex_q);
    chk({tag, ".q"}, 64'(qo), 64'(q));
    @(negedge clk);
    mem_ack = 1'b0; mem_err = 1'b0;
    if (drop[0]) set_req(sel, 1'b0, 1'b0);
    if (drop[1]) set_req(sel, 1'b1, 1'b0);
    #1;
    chk({tag, ".idle_req"},  64'(sel ? p_mem_req  : mem_req),  64'(0));
    chk({tag, ".idle_busy"}, 64'(sel ? p_arb_busy : arb_busy), 64'(0));
    resp = sel ? {p_du_err, p_du_ack, p_ex_err, p_ex_ack} : {du_err, du_ack, ex_err, ex_ack};
    chk({tag, ".idle_resp"}, 64'(resp), 64'(0));
    $display("[TB] %s resp=%04b q=%08h", tag, exp_resp, q);
  endtask

  initial begin
    #200000;
    $display("FAIL tb_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    rst = 1'b1;
    ex_req = 0; du_req = 0; p_ex_req = 0; p_du_req = 0;
    ex_adr = 0; ex_d = 0; ex_we = 0; ex_size = 0;
    du_adr = 0; du_d = 0; du_we = 0; du_size = 0;
    mem_ack = 0; mem_err = 0; mem_q = 0;
    model_last = 2'b11;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst.mem_req",  64'(mem_req),    64'(0));
    chk("rst.busy",     64'(arb_busy),   64'(0));
    chk("rst.gnt_du",   64'(arb_gnt_du), 64'(0));
    chk("rst.mem_adr",  64'(mem_adr),    64'(0));
    chk("rst.mem_d",    64'(mem_d),      64'(0));
    chk("rst.mem_we",   64'(mem_we),     64'(0));
    chk("rst.mem_size", 64'(mem_size),   64'(0));
    chk("rst.resp",     64'({du_err, du_ack, ex_err, ex_ack}), 64'(0));
    chk("rst.p_mem_req", 64'(p_mem_req), 64'(0));
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("idle.mem_req", 64'(mem_req), 64'(0));

    // Contention after reset: EX first, then DU
    ex_adr = 32'h200; ex_d = 32'h0;    ex_we = 0; ex_size = 3'd2;
    du_adr = 32'h300; du_d = 32'h55AA; du_we = 1; du_size = 3'd2;
    ex_req = 1; du_req = 1;
    expect_grant(0, 1, 1);
    expect_grant(0, 0, 1);
    wait_grant(0, "cont1"); serve(0, 0, 1, 0, 32'h1111_0001, 2'b01, "cont1");
    wait_grant(0, "cont2"); serve(0, 0, 1, 0, 32'h2222_0002, 2'b10, "cont2");

    // Both held: EX, DU, EX
    ex_adr = 32'h204; du_adr = 32'h304; ex_d = 32'h77; du_d = 32'h88;
    ex_req = 1; du_req = 1;
    expect_grant(0, 1, 1); expect_grant(0, 1, 1); expect_grant(0, 1, 1);
    wait_grant(0, "alt1"); serve(0, 0, 1, 0, 32'h0A0A_0001, 2'b00, "alt1");
    wait_grant(0, "alt2"); serve(0, 0, 1, 0, 32'h0A0A_0002, 2'b00, "alt2");
    wait_grant(0, "alt3"); serve(0, 0, 1, 0, 32'h0A0A_0003, 2'b11, "alt3");

    // Single EX read, ack one cycle after the first BUSY cycle
    ex_adr = 32'h100; ex_we = 0; ex_d = 0; ex_size = 3'd2; ex_req = 1;
    expect_grant(0, 1, 0);
    wait_grant(0, "rd"); serve(0, 1, 1, 0, 32'hDEAD_BEEF, 2'b01, "rd");

    // DU write with memory error on the first BUSY cycle
    du_adr = 32'h3; du_we = 1; du_d = 32'hCAFE; du_size = 3'd2; du_req = 1;
    expect_grant(0, 0, 1);
    wait_grant(0, "derr"); serve(0, 0, 0, 1, 32'h0, 2'b10, "derr");

    // ack and err together: err only
    ex_adr = 32'h10; ex_we = 0; ex_size = 3'd1; ex_req = 1;
    expect_grant(0, 1, 0);
    wait_grant(0, "ackerr"); serve(0, 2, 1, 1, 32'h1234, 2'b01, "ackerr");

    // ack in the same cycle the watchdog would fire: ack wins
    ex_adr = 32'h20; ex_size = 3'd2; ex_req = 1;
    expect_grant(0, 1, 0);
    wait_grant(0, "tmoack"); serve(0, 3, 1, 0, 32'hA5A5_A5A5, 2'b01, "tmoack");

    // Watchdog expiry in the 4th BUSY cycle
    ex_adr = 32'h30; ex_req = 1;
    expect_grant(0, 1, 0);
    wait_grant(0, "wdog");
    for (int i = 1; i <= 4; i++) begin
      chk("wdog.err", 64'(ex_err), 64'(i == 4));
      chk("wdog.ack", 64'({du_err, du_ack, ex_ack}), 64'(0));
      chk("wdog.req", 64'(mem_req), 64'(1));
      if (i < 4) begin
        @(negedge clk); #1;
      end
    end
    @(negedge clk);
    ex_req = 0;
    #1;
    chk("wdog.idle_req",  64'(mem_req),  64'(0));
    chk("wdog.idle_busy", 64'(arb_busy), 64'(0));
    mem_ack = 1; mem_q = 32'h77;
    #1;
    chk("wdog.late_ack", 64'({du_ack, ex_ack, du_err, ex_err}), 64'(0));
    @(negedge clk);
    mem_ack = 0;
    #1;
    chk("wdog.no_regrant", 64'(mem_req), 64'(0));
    $display("[TB] wdog timeout err observed, late ack ignored");

    // Reset in the 2nd BUSY cycle with an ack present
    ex_adr = 32'h40; ex_req = 1;
    expect_grant(0, 1, 0);
    wait_grant(0, "rstmid");
    @(negedge clk);
    rst = 1; mem_ack = 1; mem_q = 32'h99;
    #1;
    chk("rstmid.ack_sup", 64'({du_ack, ex_ack, du_err, ex_err}), 64'(0));
    chk("rstmid.req_hi",  64'(mem_req), 64'(1));
    @(negedge clk);
    rst = 0; ex_req = 0;
    #1;
    chk("rstmid.req",    64'(mem_req),    64'(0));
    chk("rstmid.busy",   64'(arb_busy),   64'(0));
    chk("rstmid.gnt",    64'(arb_gnt_du), 64'(0));
    chk("rstmid.stray",  64'({du_ack, ex_ack, du_err, ex_err}), 64'(0));
    @(negedge clk);
    mem_ack = 0;
    #1;
    chk("rstmid.after", 64'(mem_req), 64'(0));
    model_last = 2'b11;
    $display("[TB] rstmid aborted transaction");

    // Fixed DU priority: DU keeps re-requesting, EX starves until DU stops
    ex_adr = 32'h400; ex_d = 32'h4; ex_we = 0; ex_size = 3'd2;
    du_adr = 32'h500; du_d = 32'h5; du_we = 1; du_size = 3'd0;
    p_ex_req = 1; p_du_req = 1;
    expect_grant(1, 1, 1); expect_grant(1, 1, 1); expect_grant(1, 1, 1);
    expect_grant(1, 1, 0);
    wait_grant(1, "prio1"); serve(1, 0, 1, 0, 32'hB000_0001, 2'b00, "prio1");
    wait_grant(1, "prio2"); serve(1, 0, 1, 0, 32'hB000_0002, 2'b00, "prio2");
    wait_grant(1, "prio3"); serve(1, 0, 1, 0, 32'hB000_0003, 2'b10, "prio3");
    wait_grant(1, "prio4"); serve(1, 0, 1, 0, 32'hB000_0004, 2'b01, "prio4");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
